// File: rtl/fpu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fpu_scheduler
// Brief    : Single-outstanding scheduler between a core and ten FPU units:
//            issue strobe, bounded wait for the result, held response.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [7:0]  req_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] fpu_data_a,
    output logic [31:0] fpu_data_b,
    output logic [7:0]  fpu_data_c,
    output logic [9:0]  fpu_in_valid,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_valid,
    output logic        busy
);

    localparam logic [3:0] c_NUM_UNITS = 4'd10;
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [7:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [7:0]  r_c;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic        w_accept;
    logic        w_legal;
    logic        w_timeout;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_legal   = (req_op < c_NUM_UNITS);
    assign w_timeout = (r_cnt == c_WAIT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_legal ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (fpu_out_valid || w_timeout) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_c  <= req_c;
                r_op <= req_op;
                if (!w_legal) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                end
            end
            // Counter is cleared in ISSUE so WAIT always starts from zero.
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // A result arriving on the timeout cycle wins over the abort.
            if (r_state == S_WAIT) begin
                if (fpu_out_valid) begin
                    r_resp_data <= fpu_out;
                    r_resp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                end
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign resp_data    = r_resp_data;
    assign resp_err     = r_resp_err;
    assign fpu_data_a   = r_a;
    assign fpu_data_b   = r_b;
    assign fpu_data_c   = r_c;
    assign fpu_in_valid = (r_state == S_ISSUE) ? (10'd1 << r_op) : 10'd0;

endmodule
`default_nettype wire

// File: tb/tb_fpu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_scheduler
// Brief    : Directed scenarios plus random traffic against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_scheduler;

    localparam int TO  = 4;
    localparam int INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_c;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] fpu_data_a;
    logic [31:0] fpu_data_b;
    logic [7:0]  fpu_data_c;
    logic [9:0]  fpu_in_valid;
    logic [31:0] fpu_out;
    logic        fpu_out_valid;
    logic        busy;

    fpu_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_data_c(fpu_data_c),
        .fpu_in_valid(fpu_in_valid), .fpu_out(fpu_out),
        .fpu_out_valid(fpu_out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: one operation described by its accept cycle and response start cycle.
    int          cyc     = 0;
    int          m_acc   = 0;
    int          m_rs    = INF;
    bit          m_act   = 1'b0;
    bit          m_legal = 1'b0;
    logic [3:0]  m_op    = '0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [7:0]  m_c     = '0;
    logic [31:0] m_rdata = '0;
    logic        m_rerr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_in(input bit rv, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] c, input bit rr,
                          input bit fov, input logic [31:0] fo);
        req_valid     = rv;
        req_op        = op;
        req_a         = a;
        req_b         = b;
        req_c         = c;
        resp_ready    = rr;
        fpu_out_valid = fov;
        fpu_out       = fo;
    endtask

    task automatic cycle();
        logic [9:0] exp_strobe;
        bit         exp_rv;
        @(posedge clk);
        if (rst) begin
            m_act   = 1'b0;
            m_a     = '0;
            m_b     = '0;
            m_c     = '0;
            m_rdata = '0;
            m_rerr  = 1'b0;
        end else if (!m_act) begin
            if (req_valid) begin
                m_act   = 1'b1;
                m_acc   = cyc;
                m_op    = req_op;
                m_legal = (req_op < 4'd10);
                m_a     = req_a;
                m_b     = req_b;
                m_c     = req_c;
                if (!m_legal) begin
                    m_rs    = cyc + 1;
                    m_rdata = '0;
                    m_rerr  = 1'b1;
                end else begin
                    m_rs = INF;
                end
            end
        end else if (m_legal && cyc >= m_acc + 2 && cyc < m_rs) begin
            if (fpu_out_valid) begin
                m_rs    = cyc + 1;
                m_rdata = fpu_out;
                m_rerr  = 1'b0;
            end else if (cyc - m_acc - 2 == TO - 1) begin
                m_rs    = cyc + 1;
                m_rdata = '0;
                m_rerr  = 1'b1;
            end
        end else if (cyc >= m_rs && resp_ready) begin
            m_act = 1'b0;
        end
        cyc++;
        @(negedge clk);
        exp_strobe = (m_act && m_legal && cyc == m_acc + 1) ? (10'd1 << m_op) : 10'd0;
        exp_rv     = m_act && (cyc >= m_rs);
        chk("req_ready", req_ready, !m_act);
        chk("busy", busy, m_act);
        chk("fpu_in_valid", fpu_in_valid, exp_strobe);
        chk("resp_valid", resp_valid, exp_rv);
        chk("resp_data", resp_data, m_rdata);
        chk("resp_err", resp_err, m_rerr);
        chk("fpu_data_a", fpu_data_a, m_a);
        chk("fpu_data_b", fpu_data_b, m_b);
        chk("fpu_data_c", fpu_data_c, m_c);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_strobe", fpu_in_valid, 0);
        chk("rst_data_a", fpu_data_a, 0);
        chk("rst_busy", busy, 0);

        // Legal op 3, result three cycles after the strobe.
        set_in(1, 4'd3, 32'h3F800000, 32'h40000000, 8'h5A, 0, 0, 0);
        cycle();
        chk("legal_strobe", fpu_in_valid, 32'h008);
        chk("legal_data_a", fpu_data_a, 32'h3F800000);
        chk("legal_data_b", fpu_data_b, 32'h40000000);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("legal_strobe_off", fpu_in_valid, 0);
        cycle();
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 32'h40400000);
        cycle();
        chk("legal_resp_valid", resp_valid, 1);
        chk("legal_resp_data", resp_data, 32'h40400000);
        chk("legal_resp_err", resp_err, 0);
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        chk("legal_idle", req_ready, 1);

        // Illegal op 12.
        set_in(1, 4'd12, 32'h11111111, 32'h22222222, 8'h33, 0, 0, 0);
        cycle();
        chk("illegal_strobe", fpu_in_valid, 0);
        chk("illegal_resp_valid", resp_valid, 1);
        chk("illegal_resp_data", resp_data, 0);
        chk("illegal_resp_err", resp_err, 1);
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();

        // Timeout (no result) and tie (result on the last WAIT cycle).
        for (int k = 0; k < 2; k++) begin
            set_in(1, 4'd7, 32'hCAFE0000 + k, 32'h0, 8'h0, 0, 0, 0);
            cycle();
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 4; i++) cycle();
            chk("to_not_yet", resp_valid, 0);
            if (k == 1) set_in(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
            cycle();
            chk("to_resp_valid", resp_valid, 1);
            chk("to_resp_data", resp_data, (k == 1) ? 32'h12345678 : 32'h0);
            chk("to_resp_err", resp_err, (k == 1) ? 32'h0 : 32'h1);
            set_in(0, 0, 0, 0, 0, 1, 0, 0);
            cycle();
        end

        // Backpressure with a new request pending.
        set_in(1, 4'd1, 32'hAAAA0001, 32'hBBBB0002, 8'hCC, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
        cycle();
        set_in(1, 4'd2, 32'h0, 32'h0, 8'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_data", resp_data, 32'hA5A5A5A5);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_strobe", fpu_in_valid, 0);
        end
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();

        // Reset while waiting, late result afterwards.
        set_in(1, 4'd5, 32'h5, 32'h6, 8'h7, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        cycle();
        chk("rw_resp_valid", resp_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_req_ready", req_ready, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                   $urandom, $urandom, 8'($urandom),
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) == 0, $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
